// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: M-stage sequencer for req/gnt/rvalid data-memory accesses,
// with store lane replication, load alignment/extension and timeout/misalignment squash.
module mem_access_ctrl #(
  parameter int XLEN     = 32,
  parameter int TIMEOUT  = 255,
  parameter int TO_WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            ED_commit_i,
  input  logic            ED_mem_rd_i,
  input  logic            ED_mem_wr_i,
  input  logic [1:0]      ED_size_i,
  input  logic            ED_unsigned_i,
  input  logic [XLEN-1:0] ED_valE_i,
  input  logic [XLEN-1:0] ED_wdata_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [3:0]      dmem_be_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic [XLEN-1:0] M_valM_o,
  output logic            M_stall_o,
  output logic            M_bubble_o,
  output logic            err_o,
  input  logic            err_clr_i
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;
  state_t               state_q, state_d;
  logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]      data_q, data_d;
  logic                 err_q, err_d;
  logic                 access, mis, to_hit, ext;
  logic [XLEN-1:0]      sh, fmt;
  always_comb begin
    // Gating with rst keeps every output at its idle value while reset is held.
    access       = ED_commit_i & (ED_mem_rd_i | ED_mem_wr_i) & ~rst;
    mis          = (ED_size_i == 2'd3) | ((ED_size_i == 2'd1) & ED_valE_i[0]) |
                   ((ED_size_i == 2'd2) & (|ED_valE_i[1:0]));
    dmem_addr_o  = {ED_valE_i[XLEN-1:2], 2'b00};
    dmem_be_o    = ED_size_i == 2'd0 ? 4'b0001 << ED_valE_i[1:0] :
                   ED_size_i == 2'd1 ? 4'b0011 << ED_valE_i[1:0] : 4'b1111;
    dmem_wdata_o = ED_size_i == 2'd0 ? {4{ED_wdata_i[7:0]}} :
                   ED_size_i == 2'd1 ? {2{ED_wdata_i[15:0]}} : ED_wdata_i;
    sh           = dmem_rdata_i >> {ED_valE_i[1:0], 3'b000};
    ext          = ~ED_unsigned_i & (ED_size_i == 2'd0 ? sh[7] : sh[15]);
    fmt          = ED_size_i == 2'd0 ? {{(XLEN-8){ext}}, sh[7:0]} :
                   ED_size_i == 2'd1 ? {{(XLEN-16){ext}}, sh[15:0]} : sh;
    to_hit       = cnt_q >= TO_WIDTH'(TIMEOUT - 1);
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    err_d        = err_q & ~err_clr_i;
    dmem_req_o   = 1'b0;
    M_stall_o    = 1'b0;
    M_bubble_o   = 1'b0;
    M_valM_o     = '0;
    case (state_q)
      IDLE: if (access) begin
        M_stall_o  = 1'b1;
        dmem_req_o = ~mis;
        cnt_d      = '0;
        state_d    = mis ? ERR : dmem_gnt_i ? WAIT : REQ;
      end
      REQ: begin
        M_stall_o  = 1'b1;
        dmem_req_o = 1'b1;
        cnt_d      = cnt_q + TO_WIDTH'(1);
        state_d    = dmem_gnt_i ? WAIT : to_hit ? ERR : REQ;
      end
      WAIT: begin
        M_stall_o = 1'b1;
        cnt_d     = cnt_q + TO_WIDTH'(1);
        data_d    = dmem_rvalid_i ? fmt : data_q;
        state_d   = dmem_rvalid_i ? DONE : to_hit ? ERR : WAIT;
      end
      DONE: begin
        M_valM_o = ED_mem_rd_i ? data_q : '0;
        state_d  = IDLE;
      end
      ERR: begin
        M_bubble_o = 1'b1;
        err_d      = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    dmem_we_o = dmem_req_o & ED_mem_wr_i;
    err_o     = err_q;
  end
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequences the memory (M) stage of the multi-cycle pipeline. It turns the load/store fields of the E→M stage into a req/gnt/rvalid transaction on the data-memory port and formats store data and byte enables. It aligns and sign-extends load data into `M_valM_o`, and drives `M_stall_o` / `M_bubble_o` so the M/W pipeline register captures a result only once the access has finished. Misaligned and timed-out accesses are squashed into a bubble and reported on a sticky error flag.

## Interface
- `XLEN`, 32: data width; only 32 is supported.
- `TIMEOUT`, 255: maximum cycles spent in REQ+WAIT before abort (1..2^TO_WIDTH-1).
- `TO_WIDTH`, 8: width of the timeout counter.
- `clk_i`  in  1  clock.
- `rst`  in  1  reset; asynchronous and active-high.
- `ED_commit_i`  in  1  M-stage slot holds a real instruction.
- `ED_mem_rd_i` / `ED_mem_wr_i`  in  1 each  load / store (never both).
- `ED_size_i`  in  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
- `ED_unsigned_i`  in  1  zero-extend load.
- `ED_valE_i`  in  XLEN  byte address.
- `ED_wdata_i`  in  XLEN  store data, LSB-aligned.
- `dmem_req_o`  out  1  request valid.
- `dmem_we_o`  out  1  write request.
- `dmem_addr_o`  out  XLEN  word address: `{ED_valE_i[31:2],2'b00}`.
- `dmem_be_o`  out  4  byte enables.
- `dmem_wdata_o`  out  XLEN  store data, replicated per lane.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  response; read data or write ack.
- `dmem_rdata_i`  in  XLEN  read word.
- `M_valM_o`  out  XLEN  formatted load result for M/W register.
- `M_stall_o`  out  1  hold M/W register and all upstream stages.
- `M_bubble_o`  out  1  load nop into M/W register.
- `err_o`  out  1  sticky misaligned/timeout flag.
- `err_clr_i`  in  1  clears `err_o`.

## Operation
- Access = `ED_commit_i & (ED_mem_rd_i | ED_mem_wr_i)`.
- ED inputs are stable while `M_stall_o`=1; dmem address/data/be are driven combinationally from them.
- Byte enables:
  - byte: `4'b0001 << addr[1:0]`;
  - half: `4'b0011 << addr[1:0]`;
  - word: `4'b1111`.
- Misaligned = half with `addr[0]`=1, word with `addr[1:0]`≠0, or `ED_size_i`=3.
- Store data: byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → as-is.
- Load format: `rdata >> (8*addr[1:0])`, truncate to size, then sign-extend (or zero-extend if `ED_unsigned_i`). The result is latched in `data_q` on `dmem_rvalid_i`.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
  - IDLE, no access: `M_stall_o`=0, `M_valM_o`=0, no request.
  - IDLE, access and misaligned: no request; `M_stall_o`=1 → ERR.
  - IDLE, access and aligned: `dmem_req_o`=1, `M_stall_o`=1; → WAIT if `dmem_gnt_i`, else → REQ.
  - REQ: `dmem_req_o`=1, `M_stall_o`=1; → WAIT on gnt.
  - WAIT: `dmem_req_o`=0, `M_stall_o`=1; on `dmem_rvalid_i`, latch `data_q` → DONE.
  - DONE: `M_stall_o`=0; `M_valM_o`=`data_q` for loads, 0 for stores → IDLE. The M/W register captures on this edge.
  - ERR: `M_stall_o`=0, `M_bubble_o`=1, set `err_o` → IDLE.
- `dmem_rvalid_i` in any state other than WAIT is ignored.
- Timeout: counter cleared on entering REQ/WAIT from IDLE and incremented each cycle in REQ or WAIT. When it reaches `TIMEOUT` → ERR and `dmem_req_o` drops. A late rvalid after the abort is ignored.
- `err_o` set and `err_clr_i` in the same cycle: set wins.
- `M_bubble_o` is 0 in every state except ERR.

## Timing
- Reset (async): state IDLE, counter 0, `data_q`=0, `err_o`=0. Combinational outputs follow IDLE with no access, so all are 0.
- Reset mid-access drops `dmem_req_o` immediately. The in-flight response is ignored after reset.
- Non-memory instruction: zero added latency.
- Best case (gnt in IDLE, rvalid next cycle): stall for 2 cycles, result captured at end of cycle 3.
- Each cycle of gnt delay or rvalid delay adds one stall cycle.
- Misaligned access: 1 stall cycle, then a bubble.
- Back-to-back accesses: the second access enters IDLE the cycle after DONE.

## Test plan
- Word load, addr 0x100, gnt at cycle 0, rvalid at cycle 1 with 0xDEADBEEF → `M_stall_o`=1,1,0; `M_valM_o`=0xDEADBEEF in DONE.
- Signed byte load, addr 0x103, rdata 0x80112233 → be=4'b1000, `M_valM_o`=0xFFFFFF80. Same access unsigned → 0x00000080.
- Half store, addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles → req held 4 cycles; be=4'b1100, wdata=0xABCDABCD, `dmem_we_o`=1.
- Word load at addr 0x101 → no `dmem_req_o`; `M_bubble_o`=1 in cycle 1; `err_o`=1 until `err_clr_i`.
- `TIMEOUT`=4, gnt given but rvalid never → ERR after 4 cycles in REQ/WAIT, bubble, `err_o`=1. A later rvalid is ignored and the FSM stays in IDLE.
- Assert `rst` while in WAIT → `dmem_req_o`=0, `M_stall_o`=0, state IDLE immediately. A following load completes normally.
